// File: rtl/sm_cmd_tx.sv
// sm_cmd_tx: accepts one nop / write-word / write-block / read-word request at a
// time and serializes it into the sm_seq op-word stream (op word, address, data),
// capturing the read return from the sequencer output word.
// Optional feature macro: SM_CMD_TX_BLK_EN enables write-block support; without it
// a write-block request is swallowed and flagged on cmd_err.
module sm_cmd_tx #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned BLK_LEN = 4,
   parameter int unsigned RD_LAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic [DATA_W-1:0] seq_word,
   input  logic [DATA_W-1:0] seq_out,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] rd_addr,
   output logic              busy,
   output logic              cmd_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OP,
      S_ADDR,
      S_DATA,
      S_RDWAIT,
      S_GAP
   } state_e;

   typedef enum logic [1:0] {
      REQ_NOP    = 2'b00,
      REQ_WT_WD  = 2'b01,
      REQ_WT_BLK = 2'b10,
      REQ_RD_WD  = 2'b11
   } req_op_e;

   localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);
`ifdef SM_CMD_TX_BLK_EN
   localparam logic [3:0] BLK_LAST = 4'(BLK_LEN - 1);
`endif

   state_e            state_q, state_d;
   req_op_e           op_q, op_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] seq_word_q, seq_word_d;
   logic              cap;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q, rd_addr_q;
`ifndef SM_CMD_TX_BLK_EN
   logic              err_d;
   logic              cmd_err_q;
`endif

   function automatic logic [DATA_W-1:0] op_word(input req_op_e op);
      logic [3:0] opc;
      case (op)
         REQ_WT_WD:  opc = 4'b0010;
         REQ_WT_BLK: opc = 4'b0011;
         REQ_RD_WD:  opc = 4'b0100;
         default:    opc = 4'b0000;
      endcase
      return {opc, {(DATA_W-4){1'b0}}};
   endfunction

   // State and datapath registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= REQ_NOP;
         addr_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
         seq_word_q <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_addr_q  <= '0;
`ifndef SM_CMD_TX_BLK_EN
         cmd_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         seq_word_q <= seq_word_d;
         rd_valid_q <= cap;
         if (cap) begin
            rd_data_q <= seq_out;
            rd_addr_q <= addr_q;
         end
`ifndef SM_CMD_TX_BLK_EN
         cmd_err_q  <= err_d;
`endif
      end
   end

   // Next-state logic: request latch, sequencing, block word and read-wait counting.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
`ifndef SM_CMD_TX_BLK_EN
      err_d   = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            // req_ready is high in IDLE whenever reset is not overriding the update
            if (req_valid) begin
`ifndef SM_CMD_TX_BLK_EN
               if (req_op_e'(req_op) == REQ_WT_BLK) begin
                  err_d = 1'b1;
               end else begin
                  op_d    = req_op_e'(req_op);
                  addr_d  = req_addr;
                  data_d  = req_data;
                  state_d = S_OP;
               end
`else
               op_d    = req_op_e'(req_op);
               addr_d  = req_addr;
               data_d  = req_data;
               state_d = S_OP;
`endif
            end
         end
         S_OP: begin
            state_d = (op_q == REQ_NOP) ? S_GAP : S_ADDR;
         end
         S_ADDR: begin
            cnt_d   = '0;
            state_d = (op_q == REQ_RD_WD) ? S_RDWAIT : S_DATA;
         end
         S_DATA: begin
`ifdef SM_CMD_TX_BLK_EN
            if ((op_q == REQ_WT_BLK) && (cnt_q != BLK_LAST)) begin
               cnt_d  = cnt_q + 4'd1;
               data_d = data_q + DATA_W'(1);
            end else begin
               state_d = S_GAP;
            end
`else
            state_d = S_GAP;
`endif
         end
         S_RDWAIT: begin
            if (cnt_q == RD_LAST) begin
               cap     = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output word for the coming cycle, decoded from the next state so seq_word is a flop.
   always_comb begin
      seq_word_d = '0;
      unique case (state_d)
         S_OP:    seq_word_d = op_word(op_d);
         S_ADDR:  seq_word_d = addr_d;
         S_DATA:  seq_word_d = data_d;
         default: seq_word_d = '0;
      endcase
   end

   assign req_ready = (state_q == S_IDLE) && !rst;
   assign busy      = (state_q != S_IDLE);
   assign seq_word  = seq_word_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign rd_addr   = rd_addr_q;
`ifdef SM_CMD_TX_BLK_EN
   assign cmd_err   = 1'b0;
`else
   assign cmd_err   = cmd_err_q;
`endif

endmodule

// File: tb/tb_sm_cmd_tx.sv
// tb_sm_cmd_tx: directed and randomized checks of sm_cmd_tx against a queue-based
// stream model of the expected sequencer words.
module tb_sm_cmd_tx;

   localparam int unsigned DW = 32;
   localparam int unsigned BL = 4;
   localparam int unsigned RL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [1:0]    req_op = 2'b00;
   logic [DW-1:0] req_addr = '0;
   logic [DW-1:0] req_data = '0;
   logic [DW-1:0] seq_out = '0;
   logic          req_ready;
   logic [DW-1:0] seq_word;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] rd_addr;
   logic          busy;
   logic          cmd_err;

   sm_cmd_tx #(.DATA_W(DW), .BLK_LEN(BL), .RD_LAT(RL)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .seq_word  (seq_word),
      .seq_out   (seq_out),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_addr   (rd_addr),
      .busy      (busy),
      .cmd_err   (cmd_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Stream model: each accepted request appends the words it must produce, one per cycle.
   logic [31:0] mq[$];
   bit          m_live = 0;
   bit          m_busy = 0;
   bit          m_rv = 0;
   bit          m_err = 0;
   bit          m_pend = 0;
   logic [31:0] m_word = '0;
   logic [31:0] m_rd_data = '0;
   logic [31:0] m_rd_addr = '0;
   logic [31:0] m_pend_addr = '0;
   int          acc_cnt = 0;

   always @(posedge clk) begin
      m_rv  = 0;
      m_err = 0;
      if (rst) begin
         mq.delete();
         m_live    = 1;
         m_busy    = 0;
         m_word    = '0;
         m_rd_data = '0;
         m_rd_addr = '0;
         m_pend    = 0;
      end else begin
         if (m_pend && mq.size() == 0) begin
            m_pend    = 0;
            m_rv      = 1;
            m_rd_data = seq_out;
            m_rd_addr = m_pend_addr;
         end
         if (!m_busy && req_valid) begin
            acc_cnt++;
            case (req_op)
               2'b00: begin
                  mq.push_back(32'h0);
                  mq.push_back(32'h0);
               end
               2'b01: begin
                  mq.push_back(32'h2000_0000);
                  mq.push_back(req_addr);
                  mq.push_back(req_data);
                  mq.push_back(32'h0);
               end
               2'b10: begin
`ifdef SM_CMD_TX_BLK_EN
                  mq.push_back(32'h3000_0000);
                  mq.push_back(req_addr);
                  for (int i = 0; i < int'(BL); i++) mq.push_back(req_data + 32'(i));
                  mq.push_back(32'h0);
`else
                  m_err = 1;
`endif
               end
               default: begin
                  mq.push_back(32'h4000_0000);
                  mq.push_back(req_addr);
                  for (int i = 0; i < int'(RL); i++) mq.push_back(32'h0);
                  m_pend      = 1;
                  m_pend_addr = req_addr;
               end
            endcase
         end
         if (mq.size() > 0) begin
            m_word = mq.pop_front();
            m_busy = 1;
         end else begin
            m_word = '0;
            m_busy = 0;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(posedge clk) begin
      #1;
      if (m_live) begin
         chk("seq_word",  seq_word, m_word);
         chk("req_ready", 32'(req_ready), 32'(!m_busy && !rst));
         chk("busy",      32'(busy), 32'(m_busy));
         chk("rd_valid",  32'(rd_valid), 32'(m_rv));
         chk("rd_data",   rd_data, m_rd_data);
         chk("rd_addr",   rd_addr, m_rd_addr);
         chk("cmd_err",   32'(cmd_err), 32'(m_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (m_busy && i < 100) begin
         step();
         i++;
      end
      chk("wait_idle_busy", 32'(busy), 32'h0);
   endtask

   // Present a request in an idle cycle; returns in the cycle after the handshake.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
      wait_idle();
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_data  = d;
      step();
      req_valid = 1'b0;
   endtask

   task automatic dir_wr(input logic [31:0] a, input logic [31:0] d);
      issue(2'b01, a, d);
      chk("wr_op",   seq_word, 32'h2000_0000);
      step();
      chk("wr_addr", seq_word, a);
      step();
      chk("wr_data", seq_word, d);
      step();
      chk("wr_gap",  seq_word, 32'h0);
      chk("wr_gap_ready", 32'(req_ready), 32'h0);
      step();
      chk("wr_ready_back", 32'(req_ready), 32'h1);
   endtask

   initial begin
      logic [1:0]  b2b_op[3];
      logic [31:0] b2b_addr[3];
      int          start, i;

      // reset state
      repeat (3) step();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_seq",   seq_word, 32'h0);
      chk("rst_rdv",   32'(rd_valid), 32'h0);
      rst = 1'b0;
      step();
      chk("post_rst_ready", 32'(req_ready), 32'h1);

      dir_wr(32'h0000_0100, 32'h0000_00AA);

`ifdef SM_CMD_TX_BLK_EN
      issue(2'b10, 32'h40, 32'hA10);
      chk("blk_op", seq_word, 32'h3000_0000);
      step(); chk("blk_addr", seq_word, 32'h40);
      step(); chk("blk_d0", seq_word, 32'hA10);
      step(); chk("blk_d1", seq_word, 32'hA11);
      step(); chk("blk_d2", seq_word, 32'hA12);
      step(); chk("blk_d3", seq_word, 32'hA13);
      step(); chk("blk_gap", seq_word, 32'h0);

      issue(2'b10, 32'h44, 32'hFFFF_FFFE);
      step(); chk("wrap_addr", seq_word, 32'h44);
      step(); chk("wrap_d0", seq_word, 32'hFFFF_FFFE);
      step(); chk("wrap_d1", seq_word, 32'hFFFF_FFFF);
      step(); chk("wrap_d2", seq_word, 32'h0);
      step(); chk("wrap_d3", seq_word, 32'h1);
      step(); chk("wrap_gap", seq_word, 32'h0);

      // reset during the second data word of a block
      issue(2'b10, 32'h80, 32'h500);
      step(); step(); step();
      chk("blkrst_d1", seq_word, 32'h501);
      rst = 1'b1;
      step();
      chk("blkrst_seq",  seq_word, 32'h0);
      chk("blkrst_busy", 32'(busy), 32'h0);
      chk("blkrst_rdv",  32'(rd_valid), 32'h0);
      rst = 1'b0;
      dir_wr(32'h0000_0200, 32'h1234_5678);
`else
      issue(2'b10, 32'h40, 32'hA10);
      chk("err_pulse", 32'(cmd_err), 32'h1);
      chk("err_seq",   seq_word, 32'h0);
      chk("err_busy",  32'(busy), 32'h0);
      step();
      chk("err_clear", 32'(cmd_err), 32'h0);
      chk("err_seq2",  seq_word, 32'h0);
      dir_wr(32'h0000_0104, 32'h0000_005A);
`endif

      // read word
      seq_out = 32'h0000_00AA;
      issue(2'b11, 32'h100, 32'h0);
      chk("rd_op", seq_word, 32'h4000_0000);
      step(); chk("rd_addr_word", seq_word, 32'h100);
      step(); chk("rd_wait0", seq_word, 32'h0);
      step(); chk("rd_wait1", seq_word, 32'h0);
      step();
      chk("rd_pulse",   32'(rd_valid), 32'h1);
      chk("rd_data_v",  rd_data, 32'hAA);
      chk("rd_addr_v",  rd_addr, 32'h100);
      chk("rd_ready",   32'(req_ready), 32'h1);
      step();
      chk("rd_pulse_end", 32'(rd_valid), 32'h0);

      // reset while a read is waiting: no read return
      seq_out = 32'h55;
      issue(2'b11, 32'h300, 32'h0);
      step(); step();
      rst = 1'b1;
      step();
      chk("rdrst_seq",  seq_word, 32'h0);
      chk("rdrst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (4) begin
         step();
         chk("rdrst_no_rdv", 32'(rd_valid), 32'h0);
      end
      dir_wr(32'h0000_0400, 32'h0000_0077);

      // back-to-back with req_valid held high
      b2b_op[0] = 2'b01; b2b_addr[0] = 32'h500;
      b2b_op[1] = 2'b11; b2b_addr[1] = 32'h600;
      b2b_op[2] = 2'b00; b2b_addr[2] = 32'h700;
      seq_out = 32'hC0DE;
      wait_idle();
      req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_op   = b2b_op[k];
         req_addr = b2b_addr[k];
         req_data = 32'h11 + 32'(k);
         start    = acc_cnt;
         i        = 0;
         step();
         while (acc_cnt == start && i < 60) begin
            step();
            i++;
         end
         chk("b2b_accept", 32'(acc_cnt - start), 32'h1);
      end
      req_valid = 1'b0;
      wait_idle();

      // randomized traffic including occasional resets
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 79) == 0);
         req_valid = ($urandom_range(0, 3) != 0);
         req_op    = 2'($urandom_range(0, 3));
         req_addr  = $urandom;
         req_data  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         seq_out   = $urandom;
         step();
      end
      rst       = 1'b0;
      req_valid = 1'b0;
      wait_idle();
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sm_cmd_tx.md
# sm_cmd_tx

Transaction-level command issuer for the functional-level memory sequencer (`sm_seq`). Accepts one request at a time (nop, write word, write block, read word) over a valid/ready handshake. Serializes each request into the sequencer's 32-bit op-word stream: op word, address, then data. Captures read data returned on the sequencer's output word. Sits between a test or traffic master and the sequencer input port, replacing hand-timed stimulus tasks with synthesizable RTL.

## Interface
- `DATA_W`, 32: width of stream words, address and data.
- `BLK_LEN`, 4: data words per write-block transaction; legal range 1..16.
- `RD_LAT`, 2: cycles from the end of the read address word to valid sequencer output; legal range 1..8.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; transfer when `req_valid && req_ready` at a posedge.
- `req_op`  in  2  00 nop, 01 wt_wd, 10 wt_blk, 11 rd_wd.
- `req_addr`  in  DATA_W  target address.
- `req_data`  in  DATA_W  write data (first word for wt_blk).
- `seq_word`  out  DATA_W  registered op-word stream to the sequencer input.
- `seq_out`  in  DATA_W  sequencer output word (read return).
- `rd_valid`  out  1  one-cycle pulse, read data valid.
- `rd_data`  out  DATA_W  captured read data.
- `rd_addr`  out  DATA_W  address of the completed read.
- `busy`  out  1  high whenever state is not IDLE.
- `cmd_err`  out  1  one-cycle pulse on an unsupported request (see Configuration).

## Operation
- Op word format: `[31:28]` = opcode, `[27:0]` = 0. Opcodes: nop 0000, wt_wd 0010, wt_blk 0011, rd_wd 0100.
- States: IDLE, OP, ADDR, DATA, RDWAIT, GAP.
- IDLE:
  - `seq_word`=0 and `req_ready`=1.
  - On handshake, latch op, addr and data, then go to OP.
- OP: drive the op word.
  - nop goes to GAP.
  - All other ops go to ADDR.
- ADDR: drive `req_addr`.
  - wt_wd and wt_blk go to DATA.
  - rd_wd goes to RDWAIT.
- DATA:
  - Drive the data word, one per cycle.
  - wt_wd: 1 word.
  - wt_blk: `BLK_LEN` words: d, d+1, …, modulo 2^DATA_W; wraps FFFF_FFFF→0.
  - Then go to GAP.
- RDWAIT:
  - Drive 0 for `RD_LAT` cycles.
  - At the posedge ending the last wait cycle, capture `seq_out` into `rd_data` and latch the address into `rd_addr`.
  - Then go to IDLE.
- GAP: drive 0 for one cycle (mandatory nop separator), then go to IDLE.
- `req_ready`=0 in every state except IDLE. Request inputs are ignored while not ready.
- Reset values: `seq_word`=0, `req_ready`=0 during the reset cycle and 1 after, `rd_valid`=0, `rd_data`=0, `rd_addr`=0, `busy`=0, `cmd_err`=0, state IDLE, block counter 0.
- Reset mid-transaction: the next cycle drives `seq_word`=0 in IDLE. The partial transaction is abandoned and never resumed. A pending read produces no `rd_valid`.

## Timing
- Handshake at edge N: op word during cycle N+1, address during N+2.
- wt_wd:
  - Data at N+3, GAP at N+4.
  - `req_ready` high again at N+5.
- wt_blk:
  - Data at N+3 … N+2+BLK_LEN.
  - GAP follows, then IDLE.
- rd_wd:
  - Zeros during N+3 … N+2+RD_LAT.
  - Capture at the edge ending N+2+RD_LAT.
  - `rd_valid` high during N+3+RD_LAT, with `req_ready`=1 in the same cycle.
- nop: op word 0 at N+1, GAP at N+2, IDLE at N+3.
- `req_valid` held high continuously: the next request is accepted in the first IDLE cycle. There is no combinational path from `req_valid` to `req_ready`.

## Configuration
- `SM_CMD_TX_BLK_EN`:
  - Defined: wt_blk is fully supported and `cmd_err` is tied 0.
  - Undefined: a wt_blk handshake completes but emits nothing. The state stays IDLE, `seq_word` stays 0, and `cmd_err` pulses during the cycle after the handshake. No block counter logic is built.

## Test plan
- wt_wd addr 0x100, data 0xAA: `seq_word` = 2000_0000, 0000_0100, 0000_00AA, 0. `req_ready` returns 5 cycles after the handshake.
- wt_blk addr 0x40, data 0xA10 (BLK_LEN=4): stream 3000_0000, 40, A10, A11, A12, A13, 0. Repeat with data FFFF_FFFE: …FFFF_FFFE, FFFF_FFFF, 0, 1.
- rd_wd addr 0x100, model drives `seq_out`=0xAA at the capture edge (RD_LAT=2): stream 4000_0000, 100, 0, 0. `rd_valid` pulses one cycle later with `rd_data`=0xAA and `rd_addr`=0x100.
- Back-to-back: `req_valid` held high across wt_wd, rd_wd, nop. Each op word is preceded by at least one zero word, and no request is dropped or duplicated.
- Reset asserted during the 2nd data word of a wt_blk: `seq_word`=0 the next cycle, `busy`=0, no `rd_valid`. A fresh wt_wd afterwards is correct.
- Without `SM_CMD_TX_BLK_EN`: wt_blk request gives a `cmd_err` pulse with `seq_word` constant 0. A following wt_wd is unaffected.
